// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache miss paths onto one physical-memory line port.
// Define ARBITER_ROUND_ROBIN_EN for alternating tie-breaks; otherwise the D-cache has fixed priority.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,

  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       i_req;
  logic       d_req;
  logic       grant_d;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_grant_d;

  // A tie goes to whoever was not granted last; a lone request always wins.
  assign grant_d = d_req & (~i_req | ~last_grant_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && (i_req || d_req)) begin
      last_grant_d <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_req || d_req) state_next = grant_d ? SERVE_D : SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    pmem_address      = '0;
    pmem_wdata        = '0;
    icache_pmem_resp  = 1'b0;
    dcache_pmem_resp  = 1'b0;
    icache_pmem_rdata = '0;
    dcache_pmem_rdata = '0;
    case (state)
      SERVE_I: begin
        pmem_read         = 1'b1;
        pmem_address      = icache_pmem_address;
        icache_pmem_resp  = pmem_resp;
        icache_pmem_rdata = pmem_rdata;
        dcache_pmem_rdata = pmem_rdata;
      end
      SERVE_D: begin
        // Write wins if a misbehaving D-cache raises both strobes.
        pmem_read         = dcache_pmem_read & ~dcache_pmem_write;
        pmem_write        = dcache_pmem_write;
        pmem_address      = dcache_pmem_address;
        pmem_wdata        = dcache_pmem_wdata;
        dcache_pmem_resp  = pmem_resp;
        icache_pmem_rdata = pmem_rdata;
        dcache_pmem_rdata = pmem_rdata;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (!(dcache_pmem_read && dcache_pmem_write));
      assert (!(state == SERVE_I && !i_req));
      assert (!(state == SERVE_D && !d_req));
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios then randomized traffic
// checked against a request-level model of the grant rules.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_pmem_read;
  logic [AW-1:0] icache_pmem_address;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [AW-1:0] dcache_pmem_address;
  logic [LW-1:0] dcache_pmem_wdata;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side view: who is waiting, and what each one is asking for.
  logic          i_pend, d_pend, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wd;
  logic          model_last_d;
  logic          win;

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    icache_pmem_read    = i_pend;
    icache_pmem_address = i_addr;
    dcache_pmem_read    = d_pend & ~d_wr;
    dcache_pmem_write   = d_pend & d_wr;
    dcache_pmem_address = d_addr;
    dcache_pmem_wdata   = d_wd;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Grant rule straight from the arbitration policy.
  function automatic logic expect_grant_d();
    if (i_pend && d_pend) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      return !model_last_d;
`else
      return 1'b1;
`endif
    end
    return d_pend;
  endfunction

  task automatic check_idle(input string tag);
    check_b({tag, "_rd"},   pmem_read, 1'b0);
    check_b({tag, "_wr"},   pmem_write, 1'b0);
    check_a({tag, "_addr"}, pmem_address, '0);
    check_v({tag, "_wd"},   pmem_wdata, '0);
    check_v({tag, "_irdata"}, icache_pmem_rdata, '0);
    check_v({tag, "_drdata"}, dcache_pmem_rdata, '0);
    check_b({tag, "_iresp"}, icache_pmem_resp, 1'b0);
    check_b({tag, "_dresp"}, dcache_pmem_resp, 1'b0);
  endtask

  task automatic check_serving(input logic to_d);
    if (to_d) begin
      check_b("d_srv_rd",   pmem_read, !d_wr);
      check_b("d_srv_wr",   pmem_write, d_wr);
      check_a("d_srv_addr", pmem_address, d_addr);
      if (d_wr) check_v("d_srv_wd", pmem_wdata, d_wd);
    end else begin
      check_b("i_srv_rd",   pmem_read, 1'b1);
      check_b("i_srv_wr",   pmem_write, 1'b0);
      check_a("i_srv_addr", pmem_address, i_addr);
    end
    check_b("srv_iresp", icache_pmem_resp, 1'b0);
    check_b("srv_dresp", dcache_pmem_resp, 1'b0);
  endtask

  // Called in an IDLE cycle with at least one request pending: predicts the
  // winner, plays memory with the given latency, and retires that request.
  task automatic grant_and_serve(input int lat, input logic [LW-1:0] rdata, output logic won_d);
    won_d = expect_grant_d();
    check_idle("pre_grant");
    tick();
    for (int c = 0; c < lat; c++) begin
      check_serving(won_d);
      tick();
    end
    check_serving(won_d);
    pmem_rdata = rdata;
    pmem_resp  = 1'b1;
    #1;
    check_b("resp_i", icache_pmem_resp, !won_d);
    check_b("resp_d", dcache_pmem_resp, won_d);
    if (!won_d) check_v("rdata_i", icache_pmem_rdata, rdata);
    else if (!d_wr) check_v("rdata_d", dcache_pmem_rdata, rdata);
    tick();
    pmem_resp = 1'b0;
    if (won_d) d_pend = 1'b0;
    else i_pend = 1'b0;
    model_last_d = won_d;
    #1;
    check_b("post_iresp", icache_pmem_resp, 1'b0);
    check_b("post_dresp", dcache_pmem_resp, 1'b0);
    apply();
  endtask

  initial begin
    rst = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wd = '0;
    model_last_d = 1'b0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    apply();

    // Reset then idle
    tick(); tick();
    check_idle("reset");
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_idle("idle");
    end

    // Stray memory response in IDLE is ignored
    pmem_rdata = rand_line();
    pmem_resp  = 1'b1;
    #1;
    check_idle("stray_resp");
    tick();
    pmem_resp = 1'b0;
    tick();
    check_idle("after_stray");

    // Lone I-fill
    i_pend = 1'b1; i_addr = 32'h0000_0060; apply();
    grant_and_serve(4, {32{8'hA5}}, win);
    check_b("lone_i_winner", win, 1'b0);

    // D writeback
    d_pend = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_1000; d_wd = {8{32'hDEADBEEF}}; apply();
    grant_and_serve(3, rand_line(), win);
    check_b("d_wb_winner", win, 1'b1);

    // Simultaneous requests: D first under fixed priority, round-robin follows last grant
    i_pend = 1'b1; i_addr = 32'h40; d_pend = 1'b1; d_wr = 1'b0; d_addr = 32'h80; apply();
    grant_and_serve(2, rand_line(), win);
`ifndef ARBITER_ROUND_ROBIN_EN
    check_b("tie_fixed_first_d", win, 1'b1);
`endif
    grant_and_serve(2, rand_line(), win);

    // Reset mid-service in SERVE_D
    d_pend = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_2000; d_wd = rand_line(); apply();
    tick();
    check_b("mid_srv_wr", pmem_write, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    check_idle("mid_rst");
    rst = 1'b1;
    d_pend = 1'b0; model_last_d = 1'b0; apply();
    tick();
    check_idle("mid_rst_after");

    // Three fresh ties: D, I, D, I, D, I in both build flavours
    for (int k = 0; k < 3; k++) begin
      i_pend = 1'b1; i_addr = 32'h100 + AW'(k); d_pend = 1'b1; d_wr = k[0];
      d_addr = 32'h200 + AW'(k); d_wd = rand_line(); apply();
      grant_and_serve(1, rand_line(), win);
      check_b("tie_first_d", win, 1'b1);
      grant_and_serve(1, rand_line(), win);
      check_b("tie_second_i", win, 1'b0);
    end

    // D re-requests while I still waits: policy decides
    i_pend = 1'b1; i_addr = 32'h300; d_pend = 1'b1; d_wr = 1'b0; d_addr = 32'h400; apply();
    grant_and_serve(0, rand_line(), win);
    d_pend = 1'b1; d_addr = 32'h500; apply();
    grant_and_serve(2, rand_line(), win);
`ifdef ARBITER_ROUND_ROBIN_EN
    check_b("rr_no_starve", win, 1'b0);
`else
    check_b("fixed_d_wins", win, 1'b1);
`endif
    grant_and_serve(1, rand_line(), win);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1; i_addr = $urandom();
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1; d_wr = $urandom_range(0, 1) == 1; d_addr = $urandom(); d_wd = rand_line();
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1'b1; i_addr = $urandom();
      end
      apply();
      grant_and_serve($urandom_range(0, 5), rand_line(), win);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
